div_seq: RTL and testbench



---
 rtl/div_seq.sv | 175 +++++++++++++++++
 tb/tb_div_seq.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/div_seq.sv
// Multi-cycle restoring divider (signed/unsigned, one quotient bit per cycle).
// Fixed WIDTH+1 cycle latency with start/busy/done handshake and defined divide-by-zero result.
module div_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);

  localparam int            CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_dvsr;
  logic [WIDTH-1:0] r_orig;
  logic             r_neg_q;
  logic             r_neg_r;
  logic             r_dvz;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_r;
  logic             r_busy;
  logic             r_done;
  logic             r_div_zero;

  logic             w_dvd_neg;
  logic             w_dvs_neg;
  logic [WIDTH-1:0] w_dvd_mag;
  logic [WIDTH-1:0] w_dvs_mag;
  logic [WIDTH:0]   w_shift;
  logic             w_ge;
  logic [WIDTH-1:0] w_rem_nxt;
  logic [WIDTH-1:0] w_q_fix;
  logic [WIDTH-1:0] w_r_fix;

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) w_next = S_CALC;
        else       w_next = S_IDLE;
      end
      S_CALC: begin
        if (r_cnt == CNT_LAST) w_next = S_FIX;
        else                   w_next = S_CALC;
      end
      S_FIX:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Operand magnitudes, one restoring step, and final sign/zero correction.
  // The shifted partial remainder is WIDTH+1 bits; after a subtract it always fits WIDTH bits.
  always_comb begin
    w_dvd_neg = is_signed & dividend[WIDTH-1];
    w_dvs_neg = is_signed & divisor[WIDTH-1];
    w_dvd_mag = w_dvd_neg ? -dividend : dividend;
    w_dvs_mag = w_dvs_neg ? -divisor : divisor;
    w_shift   = {r_rem, r_quo[WIDTH-1]};
    w_ge      = (w_shift >= {1'b0, r_dvsr});
    if (w_ge) w_rem_nxt = w_shift[WIDTH-1:0] - r_dvsr;
    else      w_rem_nxt = w_shift[WIDTH-1:0];
    if (r_dvz) begin
      w_q_fix = {WIDTH{1'b1}};
      w_r_fix = r_orig;
    end else begin
      w_q_fix = r_neg_q ? -r_quo : r_quo;
      w_r_fix = r_neg_r ? -r_rem : r_rem;
    end
  end

  // Iteration datapath: operand capture, shift/subtract, counter
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_cnt   <= '0;
      r_rem   <= '0;
      r_quo   <= '0;
      r_dvsr  <= '0;
      r_orig  <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_dvz   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_cnt   <= '0;
            r_rem   <= '0;
            r_quo   <= w_dvd_mag;
            r_dvsr  <= w_dvs_mag;
            r_orig  <= dividend;
            r_neg_q <= w_dvd_neg ^ w_dvs_neg;
            r_neg_r <= w_dvd_neg;
            r_dvz   <= (divisor == '0);
          end else begin
            r_cnt <= r_cnt;
          end
        end
        S_CALC: begin
          r_rem <= w_rem_nxt;
          r_quo <= {r_quo[WIDTH-2:0], w_ge};
          r_cnt <= r_cnt + CNT_ONE;
        end
        default: begin
          r_cnt <= r_cnt;
        end
      endcase
    end
  end

  // Registered outputs; only FIX ever loads q/r so no partial result leaks out
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_q        <= '0;
      r_r        <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_div_zero <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) r_busy <= 1'b1;
          else       r_busy <= 1'b0;
        end
        S_FIX: begin
          r_q        <= w_q_fix;
          r_r        <= w_r_fix;
          r_div_zero <= r_dvz;
          r_done     <= 1'b1;
          r_busy     <= 1'b0;
        end
        default: begin
          r_busy <= r_busy;
        end
      endcase
    end
  end

  assign q        = r_q;
  assign r        = r_r;
  assign busy     = r_busy;
  assign done     = r_done;
  assign div_zero = r_div_zero;

endmodule

// File: tb/tb_div_seq.sv
// Directed self-checking bench for div_seq: a 32-bit and an 8-bit instance on a shared clock/reset.
module tb_div_seq;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;

  logic        st32 = 1'b0, sg32 = 1'b0;
  logic [31:0] a32 = 32'd0, b32 = 32'd0;
  logic [31:0] q32, r32;
  logic        busy32, done32, dz32;

  logic        st8 = 1'b0, sg8 = 1'b0;
  logic [7:0]  a8 = 8'd0, b8 = 8'd0;
  logic [7:0]  q8, r8;
  logic        busy8, done8, dz8;

  int n_assert = 0;
  int n_fail   = 0;
  int lat, bc, ndone;

  div_seq #(.WIDTH(32)) dut32 (
    .clock(clk), .reset(rst_n), .start(st32), .is_signed(sg32),
    .dividend(a32), .divisor(b32), .q(q32), .r(r32),
    .busy(busy32), .done(done32), .div_zero(dz32)
  );

  div_seq #(.WIDTH(8)) dut8 (
    .clock(clk), .reset(rst_n), .start(st8), .is_signed(sg8),
    .dividend(a8), .divisor(b8), .q(q8), .r(r8),
    .busy(busy8), .done(done8), .div_zero(dz8)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Present a request for one cycle, then scramble the operand inputs
  task automatic go32(input logic sg, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    st32 = 1'b1; sg32 = sg; a32 = a; b32 = b;
    @(posedge clk); #1;
    st32 = 1'b0; sg32 = ~sg; a32 = $urandom; b32 = $urandom;
  endtask

  task automatic wait32(output int l, output int b);
    l = 0;
    b = (busy32 === 1'b1) ? 1 : 0;
    while (done32 !== 1'b1 && l < 100) begin
      @(posedge clk); #1;
      l++;
      if (busy32 === 1'b1) b++;
    end
  endtask

  task automatic run32(input string tag, input logic sg, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] eq, input logic [31:0] er, input logic edz);
    go32(sg, a, b);
    wait32(lat, bc);
    chk({tag, "_lat"},  lat,    32'd33);
    chk({tag, "_busy"}, bc,     32'd33);
    chk({tag, "_q"},    q32,    eq);
    chk({tag, "_r"},    r32,    er);
    chk({tag, "_dz"},   dz32,   {31'd0, edz});
    chk({tag, "_bsy0"}, busy32, 32'd0);
  endtask

  task automatic run8(input string tag, input logic sg, input logic [7:0] a, input logic [7:0] b,
                      input logic [7:0] eq, input logic [7:0] er, input logic edz);
    @(negedge clk);
    st8 = 1'b1; sg8 = sg; a8 = a; b8 = b;
    @(posedge clk); #1;
    st8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
    lat = 0;
    bc  = (busy8 === 1'b1) ? 1 : 0;
    while (done8 !== 1'b1 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
      if (busy8 === 1'b1) bc++;
    end
    chk({tag, "_lat"},  lat, 32'd9);
    chk({tag, "_busy"}, bc,  32'd9);
    chk({tag, "_q"},    {24'd0, q8}, {24'd0, eq});
    chk({tag, "_r"},    {24'd0, r8}, {24'd0, er});
    chk({tag, "_dz"},   {31'd0, dz8}, {31'd0, edz});
  endtask

  initial begin
    #1;
    chk("rst_q",    q32,    32'd0);
    chk("rst_r",    r32,    32'd0);
    chk("rst_busy", busy32, 32'd0);
    chk("rst_done", done32, 32'd0);
    chk("rst_dz",   dz32,   32'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    run32("neg7div2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
    @(posedge clk); #1;
    chk("done_pulse", done32, 32'd0);
    chk("hold_q",     q32,    32'hFFFF_FFFD);

    run32("udiv16",  1'b0, 32'hFFFF_FFFF, 32'h10, 32'h0FFF_FFFF, 32'hF, 1'b0);
    run32("sdiv16",  1'b1, 32'hFFFF_FFFF, 32'h10, 32'h0,         32'hFFFF_FFFF, 1'b0);
    run32("dz100",   1'b1, 32'd100, 32'd0, 32'hFFFF_FFFF, 32'h64, 1'b1);
    @(posedge clk); #1;
    chk("dz_hold", dz32, 32'd1);
    run32("nine3",   1'b1, 32'd9, 32'd3, 32'd3, 32'd0, 1'b0);
    run32("ovf",     1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0);
    run32("minby1",  1'b1, 32'h8000_0000, 32'd1, 32'h8000_0000, 32'd0, 1'b0);
    run32("s7bym2",  1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 1'b0);
    run32("udz",     1'b0, 32'hDEAD_BEEF, 32'd0, 32'hFFFF_FFFF, 32'hDEAD_BEEF, 1'b1);

    // A second start during CALC must not disturb the operation in flight
    go32(1'b0, 32'd20, 32'd3);
    repeat (5) @(posedge clk);
    @(negedge clk);
    st32 = 1'b1; sg32 = 1'b1; a32 = 32'd50; b32 = 32'd5;
    @(negedge clk);
    st32 = 1'b0;
    wait32(lat, bc);
    chk("midstart_done", done32, 32'd1);
    chk("midstart_q",    q32,    32'd6);
    chk("midstart_r",    r32,    32'd2);

    // Start accepted in the done cycle
    run32("b2b", 1'b0, 32'd50, 32'd5, 32'd10, 32'd0, 1'b0);

    // Asynchronous reset at cycle 10 of an operation
    go32(1'b0, 32'h1234_5678, 32'd3);
    repeat (9) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_q",    q32,    32'd0);
    chk("arst_r",    r32,    32'd0);
    chk("arst_busy", busy32, 32'd0);
    chk("arst_done", done32, 32'd0);
    chk("arst_dz",   dz32,   32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done32 === 1'b1 || busy32 === 1'b1) ndone++;
    end
    chk("arst_quiet", ndone, 32'd0);

    run8("u200by7",  1'b0, 8'd200, 8'd7,  8'd28,  8'd4,  1'b0);
    run8("s80byff",  1'b1, 8'h80,  8'hFF, 8'h80,  8'h00, 1'b0);
    run8("sm100by7", 1'b1, 8'h9C,  8'd7,  8'hF2,  8'hFE, 1'b0);
    run8("u9cby0",   1'b0, 8'h9C,  8'd0,  8'hFF,  8'h9C, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
